alu_issue_ctrl: RTL and testbench

Initiator-side controller for the 32-bit ALU. It accepts operation requests over a valid/ready handshake and drives the ALU opcode and operand inputs from registers. It captures the ALU result and flags, then returns them over a second valid/ready handshake. It sits between the instruction sequencer and the combinational alu, screens out illegal opcodes and counts completed operations.

---
 rtl/alu_issue_ctrl.sv | 155 +++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue controller for the combinational 32-bit ALU: request handshake in, registered ALU drive, captured response out.
// Optional sticky overflow flag built when ALU_ISSUE_STICKY_EN is defined.
module alu_issue_ctrl #(
  parameter int BUS_WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [3:0]           req_opcode,
  input  logic [BUS_WIDTH-1:0] req_a,
  input  logic [BUS_WIDTH-1:0] req_b,
  output logic [3:0]           alu_opcode,
  output logic [BUS_WIDTH-1:0] alu_num_0,
  output logic [BUS_WIDTH-1:0] alu_num_1,
  input  logic [BUS_WIDTH-1:0] alu_num_out,
  input  logic                 alu_over,
  input  logic                 alu_zero,
  input  logic                 alu_greater,
  input  logic                 alu_equal,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_data,
  output logic [3:0]           rsp_flags,
  output logic                 rsp_err,
  output logic [CNT_WIDTH-1:0] op_count
`ifdef ALU_ISSUE_STICKY_EN
  ,
  input  logic                 sticky_clr,
  output logic                 sticky_over
`endif
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                 state_q, state_d;
  logic [3:0]             alu_opcode_q, alu_opcode_d;
  logic [BUS_WIDTH-1:0]   num_0_q, num_0_d;
  logic [BUS_WIDTH-1:0]   num_1_q, num_1_d;
  logic                   err_q, err_d;
  logic [BUS_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic [3:0]             rsp_flags_q, rsp_flags_d;
  logic                   rsp_err_q, rsp_err_d;
  logic [CNT_WIDTH-1:0]   op_count_q, op_count_d;
  logic                   legal_op;
  logic                   rsp_fire;

  always_comb begin
    case (req_opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011: legal_op = 1'b1;
      default:                                              legal_op = 1'b0;
    endcase
  end

  assign rsp_fire = (state_q == RESP) && rsp_ready;

  always_comb begin
    state_d      = state_q;
    alu_opcode_d = alu_opcode_q;
    num_0_d      = num_0_q;
    num_1_d      = num_1_q;
    err_d        = err_q;
    rsp_data_d   = rsp_data_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          num_0_d      = req_a;
          num_1_d      = req_b;
          // Illegal codes still exercise the ALU, but as NUL.
          alu_opcode_d = legal_op ? req_opcode : 4'b0000;
          err_d        = ~legal_op;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d   = alu_num_out;
        rsp_flags_d  = {alu_over, alu_zero, alu_greater, alu_equal};
        rsp_err_d    = err_q;
        alu_opcode_d = 4'b0000;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      alu_opcode_q <= '0;
      num_0_q      <= '0;
      num_1_q      <= '0;
      err_q        <= 1'b0;
      rsp_data_q   <= '0;
      rsp_flags_q  <= '0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_opcode_q <= alu_opcode_d;
      num_0_q      <= num_0_d;
      num_1_q      <= num_1_d;
      err_q        <= err_d;
      rsp_data_q   <= rsp_data_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

`ifdef ALU_ISSUE_STICKY_EN
  logic sticky_over_q, sticky_over_d;

  // A set on the handshake overrides a simultaneous clear.
  always_comb begin
    sticky_over_d = sticky_over_q;
    if (sticky_clr)
      sticky_over_d = 1'b0;
    if (rsp_fire && rsp_flags_q[3])
      sticky_over_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)
      sticky_over_q <= 1'b0;
    else
      sticky_over_q <= sticky_over_d;
  end

  assign sticky_over = sticky_over_q;
`else
  logic unused_fire;
  assign unused_fire = rsp_fire;
`endif

  assign req_ready  = (state_q == IDLE);
  assign rsp_valid  = (state_q == RESP);
  assign alu_opcode = alu_opcode_q;
  assign alu_num_0  = num_0_q;
  assign alu_num_1  = num_1_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed scenarios plus randomized traffic against a transaction-level model.
module tb_alu_issue_ctrl;
  localparam int BW = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [3:0]    req_opcode;
  logic [BW-1:0] req_a, req_b;
  logic [3:0]    alu_opcode;
  logic [BW-1:0] alu_num_0, alu_num_1, alu_num_out;
  logic          alu_over, alu_zero, alu_greater, alu_equal;
  logic          rsp_valid, rsp_ready;
  logic [BW-1:0] rsp_data;
  logic [3:0]    rsp_flags;
  logic          rsp_err;
  logic [CW-1:0] op_count;
`ifdef ALU_ISSUE_STICKY_EN
  logic          sticky_clr;
  logic          sticky_over;
`endif

  always #5 clk = ~clk;

  alu_issue_ctrl #(.BUS_WIDTH(BW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_a(req_a), .req_b(req_b),
    .alu_opcode(alu_opcode), .alu_num_0(alu_num_0), .alu_num_1(alu_num_1),
    .alu_num_out(alu_num_out), .alu_over(alu_over), .alu_zero(alu_zero),
    .alu_greater(alu_greater), .alu_equal(alu_equal),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_err(rsp_err), .op_count(op_count)
`ifdef ALU_ISSUE_STICKY_EN
    , .sticky_clr(sticky_clr), .sticky_over(sticky_over)
`endif
  );

  // Reference ALU: {result, over, zero, greater, equal}
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic        ov;
    s = '0; r = '0; ov = 1'b0;
    case (op)
      4'b0001: begin s = {1'b0, a} + {1'b0, b}; r = s[31:0]; ov = s[32]; end
      4'b0010: begin r = a - b; ov = (a < b); end
      4'b0100: r = a & b;
      4'b1000: r = a | b;
      4'b0011: r = a ^ b;
      default: r = '0;
    endcase
    return {r, ov, (r == 32'd0), (a > b), (a == b)};
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return (op == 4'b0000) || (op == 4'b0001) || (op == 4'b0010) ||
           (op == 4'b0100) || (op == 4'b1000) || (op == 4'b0011);
  endfunction

  always_comb {alu_num_out, alu_over, alu_zero, alu_greater, alu_equal} = alu_fn(alu_opcode, alu_num_0, alu_num_1);

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding operation, timed by cycle index.
  int          cyc = 0;
  int          acc = 0;
  bit          busy = 0;
  logic [3:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_data = '0;
  logic [3:0]  m_flags = '0;
  bit          m_err = 0;
  logic [15:0] m_cnt = '0;
  bit          m_sticky = 0;
  int          load_seq = 0;
  int          load_seen = 0;
  bit          cmp_en = 0;

  always @(posedge clk) begin
    bit hs;
    hs = 0;
    if (rst) begin
      busy = 0; m_op = '0; m_a = '0; m_b = '0; m_data = '0; m_flags = '0;
      m_err = 0; m_cnt = '0; m_sticky = 0;
      load_seen = load_seq;
    end else begin
      if (load_seq != load_seen) begin
        load_seen = load_seq;
        m_cnt = 16'hffff;
      end
      if (busy && cyc >= acc + 1 && rsp_ready) begin
        hs = 1;
        busy = 0;
        m_cnt = m_cnt + 16'd1;
      end else if (!busy && req_valid) begin
        busy = 1;
        acc = cyc + 1;
        m_a = req_a;
        m_b = req_b;
        m_op = is_legal(req_opcode) ? req_opcode : 4'b0000;
        m_err = !is_legal(req_opcode);
        {m_data, m_flags} = alu_fn(m_op, m_a, m_b);
      end
`ifdef ALU_ISSUE_STICKY_EN
      if (hs && m_flags[3]) m_sticky = 1;
      else if (sticky_clr) m_sticky = 0;
`endif
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      bit e_valid;
      e_valid = busy && (cyc >= acc + 1);
      chk("req_ready", 64'(req_ready), 64'(!busy));
      chk("rsp_valid", 64'(rsp_valid), 64'(e_valid));
      chk("alu_opcode", 64'(alu_opcode), 64'((busy && cyc == acc) ? m_op : 4'b0000));
      chk("alu_num_0", 64'(alu_num_0), 64'(m_a));
      chk("alu_num_1", 64'(alu_num_1), 64'(m_b));
      chk("op_count", 64'(op_count), 64'(m_cnt));
      if (e_valid) begin
        chk("rsp_data", 64'(rsp_data), 64'(m_data));
        chk("rsp_flags", 64'(rsp_flags), 64'(m_flags));
        chk("rsp_err", 64'(rsp_err), 64'(m_err));
      end
`ifdef ALU_ISSUE_STICKY_EN
      chk("sticky_over", 64'(sticky_over), 64'(m_sticky));
`endif
    end
  end

  // Issue one request; hold < 0 leaves the response pending.
  task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold,
                       output logic [31:0] d, output logic [3:0] f, output logic e);
    int n;
    d = '0; f = '0; e = 1'b0;
    @(negedge clk); #1;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) chk("req_ready_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b; rsp_ready = 1'b0;
    @(negedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("latency_valid", 64'(rsp_valid), 64'd1);
    d = rsp_data; f = rsp_flags; e = rsp_err;
    if (hold >= 0) begin
      repeat (hold) @(negedge clk);
      #1 rsp_ready = 1'b1;
      @(negedge clk); #1;
      rsp_ready = 1'b0;
    end
  endtask

  logic [31:0] d;
  logic [3:0]  f;
  logic        e;

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
`ifdef ALU_ISSUE_STICKY_EN
    sticky_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    cmp_en = 1;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_req_ready", 64'(req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset_alu_opcode", 64'(alu_opcode), 64'd0);
    chk("reset_op_count", 64'(op_count), 64'd0);
    chk("reset_rsp_data", 64'(rsp_data), 64'd0);
    chk("reset_rsp_flags", 64'(rsp_flags), 64'd0);

    do_op(4'b0001, 32'hfffffff1, 32'h0000000f, 0, d, f, e);
    chk("add_data", 64'(d), 64'h0);
    chk("add_zero_flag", 64'(f[2]), 64'd1);
    chk("add_count", 64'(op_count), 64'd1);
`ifdef ALU_ISSUE_STICKY_EN
    chk("sticky_set", 64'(sticky_over), 64'd1);
`endif

    do_op(4'b0010, 32'h0000ffff, 32'h0000ffff, 5, d, f, e);
    chk("sub_data", 64'(d), 64'h0);
    chk("sub_equal_flag", 64'(f[0]), 64'd1);
    chk("sub_count", 64'(op_count), 64'd2);
`ifdef ALU_ISSUE_STICKY_EN
    chk("sticky_held", 64'(sticky_over), 64'd1);
    sticky_clr = 1'b1;
    @(negedge clk); #1 sticky_clr = 1'b0;
    chk("sticky_cleared", 64'(sticky_over), 64'd0);
`endif

    do_op(4'b0111, 32'h7e7e7e7e, 32'h5555aaaa, 0, d, f, e);
    chk("illegal_err", 64'(e), 64'd1);
    chk("illegal_data", 64'(d), 64'h0);
    chk("illegal_count", 64'(op_count), 64'd3);

    do_op(4'b0100, 32'h12345678, 32'h0f0f0f0f, -1, d, f, e);
    #1 rst = 1'b1;
    @(negedge clk); #1 rst = 1'b0;
    chk("rst_resp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_resp_count", 64'(op_count), 64'd0);
    do_op(4'b0011, 32'h7e7e7e7e, 32'h5555aaaa, 1, d, f, e);
    chk("xor_data", 64'(d), 64'h2b2bd4d4);

    @(negedge clk); #2;
    force dut.op_count_q = 16'hffff;
    load_seq++;
    @(negedge clk); #2;
    release dut.op_count_q;
    do_op(4'b0100, 32'hfffffff1, 32'h00000001, 0, d, f, e);
    chk("and_data", 64'(d), 64'h1);
    chk("wrap_count", 64'(op_count), 64'h0);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      rst        = ($urandom_range(0, 199) == 0);
      req_valid  = $urandom_range(0, 1);
      req_opcode = $urandom_range(0, 15);
      req_a      = $urandom;
      req_b      = ($urandom_range(0, 7) == 0) ? req_a : $urandom;
      rsp_ready  = $urandom_range(0, 1);
`ifdef ALU_ISSUE_STICKY_EN
      sticky_clr = ($urandom_range(0, 7) == 0);
`endif
    end
    @(negedge clk); #1;
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
